// File: rtl/cla_seq_pkg.sv
// Shared definitions for the time-shared wide adder: the slice width,
// the controller state encoding and a constant-evaluable ceil(log2).
package cla_seq_pkg;

    // Width of the one physical carry-lookahead slice that is reused every pass.
    localparam int SLICE_W = 16;

    // Controller states, 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/CLA_16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups whose
// group propagate/generate feed a second lookahead level for the group carries.
// Group-level P/G are also brought out so slices can be cascaded by a parent.
module CLA_16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o,
    output logic        p_o,
    output logic        g_o
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    // Bit P/G, group P/G, group carries, in-group carries and the sum.
    always_comb begin
        p = a_i ^ b_i;
        g = a_i & b_i;

        for (int k = 0; k < 4; k++) begin
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        gc[0] = cin_i;
        gc[1] = gg[0] | (gp[0] & cin_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end

        sum_o  = p ^ c;
        cout_o = gc[4];
        p_o    = &gp;
        g_o    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder/subtractor built from a single CLA_16 slice reused once
// per cycle, least-significant slice first, with the carry held in a register
// between passes. Subtraction is a + ~b + 1: b is inverted when latched and
// the carry register is seeded with 1.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of passes through the slice; derived from WIDTH only.
    localparam int NSLICE = WIDTH / SLICE_W;
    // Index register needs at least one bit even for a single-slice adder.
    localparam int IDX_W  = (NSLICE > 1) ? clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_p;
    logic               slice_g;
    logic               unused_pg;
    logic               ovf_d;

    // A new request is taken whenever no operation is running, including the
    // DONE cycle so operations can be issued back to back.
    assign accept = start && (state_q != RUN);

    // Select the operand slice for the current pass.
    assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

    CLA_16 u_cla (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .p_o    (slice_p),
        .g_o    (slice_g)
    );

    // Group propagate/generate are not needed when the slice is time-shared.
    assign unused_pg = slice_p ^ slice_g;

    // Signed overflow on the last pass: operands (b already inverted for
    // subtract) agree in sign but the result's sign differs.
    assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);

    // Operand latches: loaded on an accepted request, otherwise held.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
        end
    end

    // Controller: sequences the passes and owns all status/result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        carry_q <= sub;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q)*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= slice_cout;
                        ovf_q   <= ovf_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder at WIDTH = 16, 32 and 64, all driven from shared
// stimulus; results are compared with a plain-arithmetic A+/-B model.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [63:0] a_in;
    logic [63:0] b_in;

    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        busy32, done32, cout32, ovf32;
    logic [31:0] sum32;
    logic        busy64, done64, cout64, ovf64;
    logic [63:0] sum64;

    int checks = 0;
    int errors = 0;

    localparam int WD [3] = '{16, 32, 64};
    localparam int NS [3] = '{1, 2, 4};

    logic [63:0] sum_w  [3];
    logic        done_w [3];
    logic        cout_w [3];
    logic        ovf_w  [3];

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a_in[15:0]), .b(b_in[15:0]),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );
    cla_seq_adder #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a_in[31:0]), .b(b_in[31:0]),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );
    cla_seq_adder #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a_in), .b(b_in),
        .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    assign sum_w[0]  = {48'd0, sum16};
    assign sum_w[1]  = {32'd0, sum32};
    assign sum_w[2]  = sum64;
    assign done_w[0] = done16;
    assign done_w[1] = done32;
    assign done_w[2] = done64;
    assign cout_w[0] = cout16;
    assign cout_w[1] = cout32;
    assign cout_w[2] = cout64;
    assign ovf_w[0]  = ovf16;
    assign ovf_w[1]  = ovf32;
    assign ovf_w[2]  = ovf64;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: w-bit modular add/subtract; carry = unsigned carry-out (for
    // subtract: 1 when a >= b, i.e. no borrow); overflow from operand/result signs.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input int w,
                                  output logic [63:0] rs, output logic rc,
                                  output logic ro);
        logic [63:0] mask;
        logic [63:0] aw;
        logic [63:0] bw;
        logic [64:0] full;
        logic        sa, sb, ss;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aw = a & mask;
        bw = b & mask;
        if (!s) begin
            full = {1'b0, aw} + {1'b0, bw};
            rc   = full[w];
        end else begin
            full = {1'b0, aw} - {1'b0, bw};
            rc   = (aw >= bw);
        end
        rs = full[63:0] & mask;
        sa = aw[w-1];
        sb = bw[w-1];
        ss = rs[w-1];
        ro = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endfunction

    // One operation on all three widths, checking done timing and results.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic s);
        logic [63:0] es [3];
        logic        ec [3];
        logic        eo [3];
        for (int i = 0; i < 3; i++) model(a, b, s, WD[i], es[i], ec[i], eo[i]);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("%s:busy_run", tag), {63'd0, busy64}, 64'd1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s:w%0d:done@%0d", tag, WD[i], n),
                    {63'd0, done_w[i]}, {63'd0, (n == NS[i])});
                if (n == NS[i]) begin
                    chk($sformatf("%s:w%0d:sum", tag, WD[i]), sum_w[i], es[i]);
                    chk($sformatf("%s:w%0d:cout", tag, WD[i]), {63'd0, cout_w[i]}, {63'd0, ec[i]});
                    chk($sformatf("%s:w%0d:ovf", tag, WD[i]), {63'd0, ovf_w[i]}, {63'd0, eo[i]});
                end
            end
            chk($sformatf("%s:busy@%0d", tag, n), {63'd0, busy64}, {63'd0, (n < 4)});
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s:w%0d:done_low", tag, WD[i]), {63'd0, done_w[i]}, 64'd0);
            chk($sformatf("%s:w%0d:sum_hold", tag, WD[i]), sum_w[i], es[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] es1, es2;
        logic        ec1, eo1, ec2, eo2;
        logic        seen;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        #2;
        chk("rst:busy", {63'd0, busy64}, 64'd0);
        chk("rst:done", {63'd0, done64}, 64'd0);
        chk("rst:sum",  sum64, 64'd0);
        chk("rst:cout", {63'd0, cout64}, 64'd0);
        chk("rst:ovf",  {63'd0, ovf64}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("carry_chain", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        run_op("full_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op("sub_borrow",  64'd5, 64'd7, 1'b1);
        run_op("sub_noborrow", 64'd7, 64'd5, 1'b1);
        run_op("signed_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

        // start pulsed while RUN must not disturb the operation in flight
        model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 64, es1, ec1, eo1);
        @(negedge clk);
        a_in = 64'h0123_4567_89AB_CDEF; b_in = 64'h1111_2222_3333_4444; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a_in = 64'hFEDC_BA98_7654_3210; b_in = 64'd5; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign:done@3", {63'd0, done64}, 64'd0);
        @(negedge clk);
        chk("ign:done@4", {63'd0, done64}, 64'd1);
        chk("ign:sum", sum64, es1);
        chk("ign:cout", {63'd0, cout64}, {63'd0, ec1});
        chk("ign:ovf", {63'd0, ovf64}, {63'd0, eo1});
        @(negedge clk);
        chk("ign:no_queue_busy", {63'd0, busy64}, 64'd0);
        chk("ign:no_queue_done", {63'd0, done64}, 64'd0);
        repeat (4) @(negedge clk);

        // start held high through DONE: second op starts with no idle cycle
        model(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 64, es1, ec1, eo1);
        model(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64, es2, ec2, eo2);
        @(negedge clk);
        a_in = 64'hFFFF_0000_FFFF_0000; b_in = 64'h0001_0000_0001_0000; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a_in = 64'h8000_0000_0000_0000; b_in = 64'd1; sub = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 4) begin
                chk("b2b:done1", {63'd0, done64}, 64'd1);
                chk("b2b:sum1", sum64, es1);
                chk("b2b:cout1", {63'd0, cout64}, {63'd0, ec1});
                chk("b2b:ovf1", {63'd0, ovf64}, {63'd0, eo1});
            end
            if (n == 5) begin
                chk("b2b:busy2", {63'd0, busy64}, 64'd1);
                chk("b2b:done_low", {63'd0, done64}, 64'd0);
                start = 1'b0;
            end
            if (n == 8) chk("b2b:done_early", {63'd0, done64}, 64'd0);
            if (n == 9) begin
                chk("b2b:done2", {63'd0, done64}, 64'd1);
                chk("b2b:sum2", sum64, es2);
                chk("b2b:cout2", {63'd0, cout64}, {63'd0, ec2});
                chk("b2b:ovf2", {63'd0, ovf64}, {63'd0, eo2});
            end
        end
        repeat (4) @(negedge clk);

        // reset in the second RUN cycle aborts the operation
        @(negedge clk);
        a_in = 64'hDEAD_BEEF_0000_1111; b_in = 64'h0000_0001_FFFF_FFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort:busy", {63'd0, busy64}, 64'd0);
        chk("abort:done", {63'd0, done64}, 64'd0);
        chk("abort:sum",  sum64, 64'd0);
        chk("abort:cout", {63'd0, cout64}, 64'd0);
        chk("abort:ovf",  {63'd0, ovf64}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done64) seen = 1'b1;
        end
        chk("abort:no_done", {63'd0, seen}, 64'd0);
        chk("abort:sum_after", sum64, 64'd0);
        chk("abort:busy_after", {63'd0, busy64}, 64'd0);

        // randomized operations on all three widths
        for (int k = 0; k < 30; k++) begin
            run_op($sformatf("rnd%0d", k), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
